// File: rtl/rps_score.sv
// Rock-paper-scissors score keeper and match controller for two players.
// Optional macro START_SYNC_EN adds a two-flop synchronizer on start.
module rps_score #(
  parameter int unsigned WIN_SCORE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] player
);

  localparam int unsigned SCORE_W = 4;
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  localparam logic [1:0] G_NONE  = 2'b00;
  localparam logic [1:0] G_ROCK  = 2'b01;
  localparam logic [1:0] G_SCIS  = 2'b10;
  localparam logic [1:0] G_PAPER = 2'b11;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_A    = 2'b01;
  localparam logic [1:0] P_B    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [SCORE_W-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic [SCORE_W-1:0]   w_a_inc, w_b_inc;
  logic [1:0]           r_player, w_player_nxt;
  logic                 r_start_q;
  logic                 w_start;
  logic                 w_go;
  logic [1:0]           w_ga, w_gb;

  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    return ((x == G_ROCK)  && (y == G_SCIS))  ||
           ((x == G_SCIS)  && (y == G_PAPER)) ||
           ((x == G_PAPER) && (y == G_ROCK));
  endfunction

`ifdef START_SYNC_EN
  logic r_sync1, r_sync2;

  // Reset-high flops so a button held through reset does not look like an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= start;
      r_sync2 <= r_sync1;
    end
  end

  assign w_start = r_sync2;
`else
  assign w_start = start;
`endif

  assign w_go    = w_start & ~r_start_q;
  assign w_ga    = key[1:0];
  assign w_gb    = key[3:2];
  assign w_a_inc = r_a + SCORE_W'(1);
  assign w_b_inc = r_b + SCORE_W'(1);

  // State and score registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_player  <= P_NONE;
      r_start_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_player  <= w_player_nxt;
      r_start_q <= w_start;
    end
  end

  // Next-state and round judging
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_player_nxt = r_player;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_go) begin
          w_a_nxt      = '0;
          w_b_nxt      = '0;
          w_player_nxt = P_NONE;
          w_state_nxt  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_go && (w_ga != G_NONE) && (w_gb != G_NONE)) begin
          if (beats(w_ga, w_gb)) begin
            w_a_nxt = w_a_inc;
            if (w_a_inc == WIN_VAL) begin
              w_player_nxt = P_A;
              w_state_nxt  = S_DONE;
            end
          end else if (beats(w_gb, w_ga)) begin
            w_b_nxt = w_b_inc;
            if (w_b_inc == WIN_VAL) begin
              w_player_nxt = P_B;
              w_state_nxt  = S_DONE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign A      = r_a;
  assign B      = r_b;
  assign player = r_player;

endmodule

// File: tb/tb_rps_score.sv
// Directed self-checking bench for rps_score with WIN_SCORE = 3.
module tb_rps_score;

`ifdef START_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] player;

  int checks   = 0;
  int failures = 0;

  rps_score #(.WIN_SCORE(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .start  (start),
    .A      (A),
    .B      (B),
    .player (player)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean start pulse: high long enough to register, then low to re-arm
  task automatic press(input logic [3:0] k);
    key   = k;
    start = 1'b1;
    repeat (LAT) tick();
    start = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic expect_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [1:0] ep);
    check({tag, "_A"}, 8'(A), 8'(ea));
    check({tag, "_B"}, 8'(B), 8'(eb));
    check({tag, "_P"}, 8'(player), 8'(ep));
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    key   = 4'b0000;
    repeat (2) tick();
    expect_all("reset", 4'd0, 4'd0, 2'b00);

    // Start held high across release must not count; winning key would expose a PLAY state
    rst = 1'b1;
    key = 4'b1001;
    repeat (4) tick();
    expect_all("release_held", 4'd0, 4'd0, 2'b00);
    start = 1'b0;
    repeat (LAT) tick();
    press(4'b1001);
    expect_all("idle_go", 4'd0, 4'd0, 2'b00);

    // A wins the match with rock vs scissors
    press(4'b1001);
    expect_all("a_win1", 4'd1, 4'd0, 2'b00);
    press(4'b1001);
    expect_all("a_win2", 4'd2, 4'd0, 2'b00);
    press(4'b1001);
    expect_all("a_win3", 4'd3, 4'd0, 2'b01);

    // DONE: key changes alone do nothing; next go restarts without judging
    key = 4'b1101;
    repeat (3) tick();
    expect_all("done_hold", 4'd3, 4'd0, 2'b01);
    press(4'b1001);
    expect_all("done_restart", 4'd0, 4'd0, 2'b00);

    press(4'b0111);
    expect_all("a_paper", 4'd1, 4'd0, 2'b00);
    press(4'b1101);
    expect_all("b_paper", 4'd1, 4'd1, 2'b00);
    press(4'b0101);
    expect_all("draw", 4'd1, 4'd1, 2'b00);
    press(4'b0001);
    expect_all("void_b", 4'd1, 4'd1, 2'b00);
    press(4'b0100);
    expect_all("void_a", 4'd1, 4'd1, 2'b00);
    press(4'b0111);
    expect_all("after_void", 4'd2, 4'd1, 2'b00);

    // Reset beats a simultaneous winning go at A=2
    rst   = 1'b0;
    key   = 4'b0111;
    start = 1'b1;
    tick();
    expect_all("rst_prio", 4'd0, 4'd0, 2'b00);
    rst   = 1'b1;
    start = 1'b0;
    repeat (LAT) tick();
    press(4'b0111);
    expect_all("rst_idle", 4'd0, 4'd0, 2'b00);

    // B wins a match; a long high start gives only one round
    press(4'b1101);
    expect_all("b_win1", 4'd0, 4'd1, 2'b00);
    key   = 4'b1101;
    start = 1'b1;
    repeat (LAT + 5) tick();
    expect_all("held_one", 4'd0, 4'd2, 2'b00);
    start = 1'b0;
    repeat (LAT) tick();
    press(4'b1101);
    expect_all("b_win3", 4'd0, 4'd3, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
